// File: rtl/csr_ctrl.sv
// Arbitrated read-modify-write front end for a CSR file shared by NREQ requesters.
// Each access runs IDLE -> READ -> WRITE -> RESP; only one access is ever in flight.
module csr_ctrl #(
  parameter int NREQ = 2,
  parameter int XLEN = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][1:0]       req_op,
  input  logic [NREQ-1:0][11:0]      req_addr,
  input  logic [NREQ-1:0][XLEN-1:0]  req_wdata,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [XLEN-1:0]            rsp_rdata,
  output logic [11:0]                csr_raddr,
  input  logic [XLEN-1:0]            csr_rdata,
  output logic                       csr_wvalid,
  output logic [11:0]                csr_waddr,
  output logic [XLEN-1:0]            csr_wdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [1:0]        op_q, op_d;
  logic [11:0]       addr_q, addr_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              wvalid_q, wvalid_d;

  logic              gnt_found_s;
  logic [IW-1:0]     gnt_idx_s;
  logic [NREQ-1:0]   ready_s;

  function automatic logic [XLEN-1:0] csr_update(input logic [1:0]      op,
                                                 input logic [XLEN-1:0] old,
                                                 input logic [XLEN-1:0] opnd);
    logic [XLEN-1:0] res;
    case (op)
      OP_RW:   res = opnd;
      OP_RS:   res = old | opnd;
      OP_RC:   res = old & ~opnd;
      default: res = old;
    endcase
    return res;
  endfunction

  // Set/clear with an all-zero mask leaves the CSR untouched, so no write strobe.
  function automatic logic needs_write(input logic [1:0]      op,
                                       input logic [XLEN-1:0] opnd);
    logic res;
    case (op)
      OP_RW:   res = 1'b1;
      OP_RS:   res = (opnd != {XLEN{1'b0}});
      OP_RC:   res = (opnd != {XLEN{1'b0}});
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Round-robin pick: search starts at the requester after the last grant.
  always_comb begin
    int unsigned   cand;
    logic [IW-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_q) + k) % NREQ;
      cand_idx = IW'(cand);
      if (!gnt_found_s && req_valid[cand_idx]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_idx;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    op_d      = op_q;
    addr_d    = addr_q;
    operand_d = operand_q;
    old_d     = old_q;
    wdata_d   = wdata_q;
    wvalid_d  = wvalid_q;
    ready_s   = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found_s) begin
          ready_s[gnt_idx_s] = 1'b1;
          grant_d   = gnt_idx_s;
          last_d    = gnt_idx_s;
          op_d      = req_op[gnt_idx_s];
          addr_d    = req_addr[gnt_idx_s];
          operand_d = req_wdata[gnt_idx_s];
          state_d   = READ;
        end else begin
          state_d   = IDLE;
        end
      end
      READ: begin
        // Write strobe/data are registered here so they appear exactly in WRITE.
        old_d    = csr_rdata;
        wdata_d  = csr_update(op_q, csr_rdata, operand_q);
        wvalid_d = needs_write(op_q, operand_q);
        state_d  = WRITE;
      end
      WRITE: begin
        wvalid_d = 1'b0;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        wvalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      last_q    <= IW'(NREQ - 1);
      grant_q   <= '0;
      op_q      <= OP_READ;
      addr_q    <= 12'h000;
      operand_q <= {XLEN{1'b0}};
      old_q     <= {XLEN{1'b0}};
      wdata_q   <= {XLEN{1'b0}};
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      old_q     <= old_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
    end
  end

  // Response decode; everything handshake-related is forced low while rstn is low.
  always_comb begin
    rsp_valid = '0;
    if (rstn && (state_q == RESP)) begin
      rsp_valid[grant_q] = 1'b1;
    end else begin
      rsp_valid = '0;
    end
  end

  assign req_ready  = ready_s & {NREQ{rstn}};
  assign csr_wvalid = wvalid_q & rstn;
  assign csr_raddr  = addr_q;
  assign csr_waddr  = addr_q;
  assign csr_wdata  = wdata_q;
  assign rsp_rdata  = old_q;

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl with a small CSR-file model and hand-computed expectations.
module tb_csr_ctrl;

  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][1:0]   req_op;
  logic [1:0][11:0]  req_addr;
  logic [1:0][63:0]  req_wdata;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [63:0]       rsp_rdata;
  logic [11:0]       csr_raddr;
  logic [63:0]       csr_rdata;
  logic              csr_wvalid;
  logic [11:0]       csr_waddr;
  logic [63:0]       csr_wdata;

  logic [63:0]       mem [0:4095];
  int                wr_count = 0;
  logic              pre_we = 1'b0;
  logic [11:0]       pre_addr = 12'h000;
  logic [63:0]       pre_data = 64'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_ctrl #(.NREQ(2), .XLEN(64)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wvalid(csr_wvalid), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata)
  );

  // CSR file model: asynchronous read, write on rising edge.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (csr_wvalid) begin
      mem[csr_waddr] <= csr_wdata;
      wr_count <= wr_count + 1;
    end
  end
  assign csr_rdata = mem[csr_raddr];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [63:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 2'b11;
    step();
    step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    checks++; if (csr_wvalid !== 1'b0) begin errors++; $display("FAIL reset_csr_wvalid got %b want 0", csr_wvalid); end
    checks++; if (csr_raddr !== 12'h000) begin errors++; $display("FAIL reset_csr_raddr got %h want 000", csr_raddr); end
    checks++; if (csr_waddr !== 12'h000) begin errors++; $display("FAIL reset_csr_waddr got %h want 000", csr_waddr); end
    checks++; if (csr_wdata !== 64'h0) begin errors++; $display("FAIL reset_csr_wdata got %h want 0", csr_wdata); end
    checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    req_valid = 2'b00;
    rstn = 1'b1;
    step();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_no_req_ready got %b want 00", req_ready); end
  endtask

  task automatic test_rs();
    int w0;
    preload(12'hB02, 64'hF0);
    w0 = wr_count;
    req_op[0] = 2'b10; req_addr[0] = 12'hB02; req_wdata[0] = 64'h0F;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rs_grant got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rs_ready_read got %b want 00", req_ready); end
    checks++; if (csr_raddr !== 12'hB02) begin errors++; $display("FAIL rs_raddr got %h want b02", csr_raddr); end
    checks++; if (csr_wvalid !== 1'b0) begin errors++; $display("FAIL rs_wvalid_read got %b want 0", csr_wvalid); end
    step();
    checks++; if (csr_wvalid !== 1'b1) begin errors++; $display("FAIL rs_wvalid got %b want 1", csr_wvalid); end
    checks++; if (csr_waddr !== 12'hB02) begin errors++; $display("FAIL rs_waddr got %h want b02", csr_waddr); end
    checks++; if (csr_wdata !== 64'hFF) begin errors++; $display("FAIL rs_wdata got %h want ff", csr_wdata); end
    step();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rs_rsp_valid got %b want 01", rsp_valid); end
    checks++; if (rsp_rdata !== 64'hF0) begin errors++; $display("FAIL rs_rsp_rdata got %h want f0", rsp_rdata); end
    checks++; if (csr_wvalid !== 1'b0) begin errors++; $display("FAIL rs_wvalid_resp got %b want 0", csr_wvalid); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rs_rsp_done got %b want 00", rsp_valid); end
    checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL rs_write_count got %0d want 1", wr_count - w0); end
    checks++; if (mem[12'hB02] !== 64'hFF) begin errors++; $display("FAIL rs_mem got %h want ff", mem[12'hB02]); end
  endtask

  task automatic test_rc_zero();
    int w0;
    preload(12'hC00, 64'h5A5A);
    w0 = wr_count;
    req_op[1] = 2'b11; req_addr[1] = 12'hC00; req_wdata[1] = 64'h0;
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rc_grant got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    checks++; if (csr_raddr !== 12'hC00) begin errors++; $display("FAIL rc_raddr got %h want c00", csr_raddr); end
    step();
    checks++; if (csr_wvalid !== 1'b0) begin errors++; $display("FAIL rc_no_write got %b want 0", csr_wvalid); end
    step();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rc_rsp_valid got %b want 10", rsp_valid); end
    checks++; if (rsp_rdata !== 64'h5A5A) begin errors++; $display("FAIL rc_rsp_rdata got %h want 5a5a", rsp_rdata); end
    // Wrong requester acknowledges and a new request arrives: both must be ignored.
    rsp_ready = 2'b01;
    req_op[0] = 2'b00;
    req_valid = 2'b01;
    step();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rc_ignore_wrong_ack got %b want 10", rsp_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rc_ready_in_resp got %b want 00", req_ready); end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rc_rsp_done got %b want 00", rsp_valid); end
    checks++; if (wr_count !== w0) begin errors++; $display("FAIL rc_write_count got %0d want %0d", wr_count, w0); end
  endtask

  task automatic test_rw_stall();
    preload(12'hB00, 64'hAAAA);
    preload(12'hC04, 64'h4444);
    req_op[0] = 2'b01; req_addr[0] = 12'hB00; req_wdata[0] = 64'h1234;
    req_op[1] = 2'b00; req_addr[1] = 12'hC04; req_wdata[1] = 64'h0;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rw_grant got %b want 01", req_ready); end
    step();
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rw_ready_read got %b want 00", req_ready); end
    step();
    checks++; if (csr_wvalid !== 1'b1) begin errors++; $display("FAIL rw_wvalid got %b want 1", csr_wvalid); end
    checks++; if (csr_wdata !== 64'h1234) begin errors++; $display("FAIL rw_wdata got %h want 1234", csr_wdata); end
    checks++; if (csr_waddr !== 12'hB00) begin errors++; $display("FAIL rw_waddr got %h want b00", csr_waddr); end
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rw_stall_valid[%0d] got %b want 01", i, rsp_valid); end
      checks++; if (rsp_rdata !== 64'hAAAA) begin errors++; $display("FAIL rw_stall_rdata[%0d] got %h want aaaa", i, rsp_rdata); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rw_stall_ready[%0d] got %b want 00", i, req_ready); end
      step();
    end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rw_next_grant got %b want 10", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rw_rsp_done got %b want 00", rsp_valid); end
    checks++; if (mem[12'hB00] !== 64'h1234) begin errors++; $display("FAIL rw_mem got %h want 1234", mem[12'hB00]); end
    step();
    req_valid = 2'b00;
    step();
    checks++; if (csr_wvalid !== 1'b0) begin errors++; $display("FAIL rd_no_write got %b want 0", csr_wvalid); end
    step();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rd_rsp_valid got %b want 10", rsp_valid); end
    checks++; if (rsp_rdata !== 64'h4444) begin errors++; $display("FAIL rd_rsp_rdata got %h want 4444", rsp_rdata); end
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy;
    logic [1:0] exp_rsp;
    rstn = 1'b0;
    step();
    req_op[0] = 2'b00; req_addr[0] = 12'hB00;
    req_op[1] = 2'b00; req_addr[1] = 12'hB02;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    rstn = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      exp_rdy = (c % 4 == 0) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rsp = (c % 4 == 3) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL b2b_rsp[%0d] got %b want %b", c, rsp_valid, exp_rsp); end
      if (c == 15) req_valid = 2'b00;
      step();
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_in_write();
    int w0;
    preload(12'hB10, 64'h9999);
    w0 = wr_count;
    req_op[1] = 2'b01; req_addr[1] = 12'hB10; req_wdata[1] = 64'h77;
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rst_w_grant got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    checks++; if (csr_wvalid !== 1'b1) begin errors++; $display("FAIL rst_w_pre_wvalid got %b want 1", csr_wvalid); end
    rstn = 1'b0;
    #1;
    checks++; if (csr_wvalid !== 1'b0) begin errors++; $display("FAIL rst_w_during got %b want 0", csr_wvalid); end
    step();
    checks++; if (csr_wvalid !== 1'b0) begin errors++; $display("FAIL rst_w_after got %b want 0", csr_wvalid); end
    checks++; if (csr_raddr !== 12'h000) begin errors++; $display("FAIL rst_w_raddr got %h want 000", csr_raddr); end
    checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL rst_w_rdata got %h want 0", rsp_rdata); end
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_w_rsp[%0d] got %b want 00", i, rsp_valid); end
      checks++; if (csr_wvalid !== 1'b0) begin errors++; $display("FAIL rst_w_wv[%0d] got %b want 0", i, csr_wvalid); end
      step();
    end
    checks++; if (wr_count !== w0) begin errors++; $display("FAIL rst_w_count got %0d want %0d", wr_count, w0); end
    checks++; if (mem[12'hB10] !== 64'h9999) begin errors++; $display("FAIL rst_w_mem got %h want 9999", mem[12'hB10]); end
    req_op[0] = 2'b00; req_op[1] = 2'b00;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_w_req0_first got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    step();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rst_w_rsp0 got %b want 01", rsp_valid); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstn      = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 2'b00;
    step();
    test_reset();
    test_rs();
    test_rc_zero();
    test_rw_stall();
    test_back_to_back();
    test_reset_in_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
